fft_frame_ctrl: RTL and testbench

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

---
 rtl/fft_frame_ctrl.sv | 131 +++++++++++++
 tb/tb_fft_frame_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// Frame controller between two ADC capture FIFOs and a streaming FFT core.
// Feeds exactly FRAME_LEN samples per frame, then waits for the FFT output frame.
module fft_frame_ctrl #(
    parameter int FRAME_LEN = 1024,
    parameter int DW        = 8
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          start,
    input  logic          cont,
    input  logic          ch_sel,
    input  logic          abort,
    input  logic          ADC0_end,
    input  logic          ADC1_end,
    input  logic          ADC0_empty,
    input  logic          ADC1_empty,
    input  logic [DW-1:0] ADC0_FIFO_O,
    input  logic [DW-1:0] ADC1_FIFO_O,
    output logic          ADC0_rdreq,
    output logic          ADC1_rdreq,
    input  logic          sink_ready,
    output logic          sink_valid,
    output logic          sink_sop,
    output logic          sink_eop,
    output logic [DW-1:0] sink_real,
    input  logic          source_valid,
    input  logic          source_sop,
    input  logic          source_eop,
    output logic          source_ready,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [2:0]    dbg_state
);

    localparam int CW = $clog2(FRAME_LEN) + 1;
    localparam logic [CW-1:0] LEN  = CW'(FRAME_LEN);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Handshakes: a FIFO word is read when rdreq=1 and appears on FIFO_O one
    // cycle later, which is exactly when sink_valid (registered rdreq) is high.
    // rdreq already includes sink_ready, matching the FFT's ready latency of 1.
    // An output beat transfers when source_valid=1 and source_ready=1.
    logic [2:0]    state, state_nxt;
    logic [CW-1:0] rd_cnt, out_cnt, out_cnt_nxt;
    logic          ch_lat, abort_pend;
    logic          sel_end, sel_empty, rd_issue, src_acc;

    assign sel_end   = ch_lat ? ADC1_end : ADC0_end;
    assign sel_empty = ch_lat ? ADC1_empty : ADC0_empty;

    // Gated by Reset_n so a reset mid-frame stops reads in the same cycle.
    assign rd_issue = Reset_n && (state == S_FEED) && sink_ready && !sel_empty && (rd_cnt < LEN);

    assign ADC0_rdreq   = rd_issue && !ch_lat;
    assign ADC1_rdreq   = rd_issue && ch_lat;
    assign sink_real    = ch_lat ? ADC1_FIFO_O : ADC0_FIFO_O;
    assign source_ready = (state == S_FEED) || (state == S_DRAIN);
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);
    assign dbg_state    = state;

    assign src_acc     = source_valid && source_ready;
    // Index of the beat being accepted now; the sop beat is index 0.
    assign out_cnt_nxt = source_sop ? '0 : out_cnt + CW'(1);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ARM;
            S_ARM: begin
                if (abort)        state_nxt = S_IDLE;
                else if (sel_end) state_nxt = S_FEED;
            end
            S_FEED:  if (sink_eop) state_nxt = S_DRAIN;
            S_DRAIN: if (src_acc && source_eop) state_nxt = S_DONE;
            S_DONE:  state_nxt = (cont && !abort_pend && !abort) ? S_ARM : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state      <= S_IDLE;
            rd_cnt     <= '0;
            out_cnt    <= '0;
            ch_lat     <= 1'b0;
            abort_pend <= 1'b0;
            sink_valid <= 1'b0;
            sink_sop   <= 1'b0;
            sink_eop   <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            sink_valid <= rd_issue;
            sink_sop   <= rd_issue && (rd_cnt == '0);
            sink_eop   <= rd_issue && (rd_cnt == LAST);

            if (state == S_ARM && state_nxt == S_FEED)
                rd_cnt <= '0;
            else if (rd_issue)
                rd_cnt <= rd_cnt + CW'(1);

            if (src_acc)
                out_cnt <= out_cnt_nxt;

            if (state == S_IDLE && start) begin
                ch_lat <= ch_sel;
                err    <= 1'b0;
            end else if (state == S_DONE && state_nxt == S_ARM) begin
                ch_lat <= ch_sel;
            end

            if (state == S_DRAIN && src_acc && source_eop && out_cnt_nxt != LAST)
                err <= 1'b1;

            // Abort during a frame lets the frame finish and is honoured at DONE.
            if (state == S_DONE)
                abort_pend <= 1'b0;
            else if (abort && (state == S_FEED || state == S_DRAIN))
                abort_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl: ADC FIFO model, FFT output driver and
// per-step immediate assertions against hand-derived expectations.
module tb_fft_frame_ctrl;

    localparam int L  = 1024;
    localparam int DW = 8;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ARM  = 3'd1;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          start = 1'b0, cont = 1'b0, ch_sel = 1'b0, abort = 1'b0;
    logic          ADC0_end = 1'b0, ADC1_end = 1'b0;
    logic          ADC0_empty = 1'b0, ADC1_empty = 1'b0;
    logic [DW-1:0] ADC0_FIFO_O = '0, ADC1_FIFO_O = '0;
    logic          ADC0_rdreq, ADC1_rdreq;
    logic          sink_ready = 1'b1;
    logic          sink_valid, sink_sop, sink_eop;
    logic [DW-1:0] sink_real;
    logic          source_valid = 1'b0, source_sop = 1'b0, source_eop = 1'b0;
    logic          source_ready, busy, done, err;
    logic [2:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    int exp_ptr0 = 0, exp_ptr1 = 0;
    int ptr0 = 0, ptr1 = 0;
    logic fifo_flush = 1'b0;
    int n_keep;

    always #5 Clk = ~Clk;

    fft_frame_ctrl #(.FRAME_LEN(L), .DW(DW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .cont(cont), .ch_sel(ch_sel),
        .abort(abort), .ADC0_end(ADC0_end), .ADC1_end(ADC1_end),
        .ADC0_empty(ADC0_empty), .ADC1_empty(ADC1_empty),
        .ADC0_FIFO_O(ADC0_FIFO_O), .ADC1_FIFO_O(ADC1_FIFO_O),
        .ADC0_rdreq(ADC0_rdreq), .ADC1_rdreq(ADC1_rdreq),
        .sink_ready(sink_ready), .sink_valid(sink_valid), .sink_sop(sink_sop),
        .sink_eop(sink_eop), .sink_real(sink_real),
        .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
        .source_ready(source_ready), .busy(busy), .done(done), .err(err),
        .dbg_state(dbg_state)
    );

    function automatic logic [DW-1:0] gen(input logic ch, input int k);
        logic [31:0] v;
        v = ch ? (k * 7 + 3) : (k ^ 32'h5A);
        return v[DW-1:0];
    endfunction

    // FIFO model: endless deterministic data, word valid one cycle after rdreq.
    always @(posedge Clk) begin
        if (fifo_flush) begin
            ptr0 <= 0;
            ptr1 <= 0;
        end else begin
            if (ADC0_rdreq) begin
                ADC0_FIFO_O <= gen(1'b0, ptr0);
                ptr0 <= ptr0 + 1;
            end
            if (ADC1_rdreq) begin
                ADC1_FIFO_O <= gen(1'b1, ptr1);
                ptr1 <= ptr1 + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic flush();
        fifo_flush = 1'b1;
        @(negedge Clk);
        fifo_flush = 1'b0;
        exp_ptr0 = 0;
        exp_ptr1 = 0;
        exp_q.delete();
    endtask

    task automatic pulse_start(input logic ch);
        ch_sel = ch;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    // Collects sink beats until a full frame, or until stop_at beats when stop_at >= 0.
    task automatic feed_frame(input logic ch, input bit rnd, input int abort_at,
                              input int chsw_at, input int stop_at);
        int beats = 0, cyc = 0, bad_rd = 0, bad_data = 0;
        int sops = 0, eops = 0, sop_idx = -1, eop_idx = -1;
        logic [DW-1:0] e;
        for (int k = 0; k < L; k++)
            exp_q.push_back(gen(ch, (ch ? exp_ptr1 : exp_ptr0) + k));
        if (ch) exp_ptr1 += L; else exp_ptr0 += L;
        while (beats < L && beats != stop_at && cyc < 20000) begin
            @(negedge Clk);
            cyc++;
            abort = 1'b0;
            if (ADC0_rdreq && ADC1_rdreq) bad_rd++;
            if (ch ? ADC0_rdreq : ADC1_rdreq) bad_rd++;
            if (sink_valid) begin
                e = exp_q.pop_front();
                if (sink_real !== e) bad_data++;
                if (sink_sop) begin sops++; sop_idx = beats; end
                if (sink_eop) begin eops++; eop_idx = beats; end
                beats++;
                if (beats == abort_at) abort = 1'b1;
                if (beats == chsw_at) ch_sel = ~ch_sel;
            end
            if (rnd) begin
                sink_ready = 1'($urandom_range(0, 1));
                ADC0_empty = ($urandom_range(0, 3) == 0);
                ADC1_empty = ($urandom_range(0, 3) == 0);
            end
        end
        sink_ready = 1'b1;
        ADC0_empty = 1'b0;
        ADC1_empty = 1'b0;
        if (stop_at >= 0) begin
            chk("feed_stop_beats", beats, stop_at);
            exp_q.delete();
        end else begin
            chk("feed_beats", beats, L);
            chk("feed_data_mismatches", bad_data, 0);
            chk("feed_sop_count", sops, 1);
            chk("feed_eop_count", eops, 1);
            chk("feed_sop_index", sop_idx, 0);
            chk("feed_eop_index", eop_idx, L - 1);
            chk("feed_rdreq_violations", bad_rd, 0);
        end
    endtask

    // Drives an FFT output frame of n beats with eop on beat eop_at (= n-1).
    task automatic send_out(input int n, input int eop_at, input logic exp_err);
        for (int i = 0; i < n; i++) begin
            source_valid = 1'b1;
            source_sop = (i == 0);
            source_eop = (i == eop_at);
            @(negedge Clk);
        end
        source_valid = 1'b0;
        source_sop = 1'b0;
        source_eop = 1'b0;
        chk("done_pulse", 32'(done), 1);
        chk("err_at_done", 32'(err), 32'(exp_err));
        @(negedge Clk);
        chk("done_one_cycle", 32'(done), 0);
    endtask

    initial begin
        // Reset state
        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        chk("reset_outputs", 32'({busy, done, err, sink_valid, sink_sop, sink_eop,
                                  source_ready, ADC0_rdreq, ADC1_rdreq}), 0);
        chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        Reset_n = 1'b1;
        @(negedge Clk);

        // Channel 0 frame; start and ch_sel changes in ARM are ignored
        pulse_start(1'b0);
        chk("arm_busy", 32'(busy), 1);
        chk("arm_state", 32'(dbg_state), 32'(ST_ARM));
        chk("arm_source_ready", 32'(source_ready), 0);
        ch_sel = 1'b1;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (2) @(negedge Clk);
        chk("arm_no_reads", ptr0 + ptr1, 0);
        ADC0_end = 1'b1;
        feed_frame(1'b0, 1'b0, -1, -1, -1);
        chk("f1_adc0_reads", ptr0, L);
        chk("f1_adc1_reads", ptr1, 0);
        send_out(L, L - 1, 1'b0);
        chk("f1_idle_after", 32'(busy), 0);

        // Channel 1 frame with random stalls
        flush();
        ADC1_end = 1'b1;
        pulse_start(1'b1);
        feed_frame(1'b1, 1'b1, -1, -1, -1);
        chk("f2_adc0_reads", ptr0, 0);
        chk("f2_adc1_reads", ptr1, L);
        send_out(L, L - 1, 1'b0);
        chk("f2_idle_after", 32'(busy), 0);

        // Abort in ARM wins over a simultaneous end
        flush();
        ADC0_end = 1'b0;
        ADC1_end = 1'b0;
        pulse_start(1'b0);
        abort = 1'b1;
        ADC0_end = 1'b1;
        @(negedge Clk);
        abort = 1'b0;
        chk("abort_arm_busy", 32'(busy), 0);
        chk("abort_arm_state", 32'(dbg_state), 32'(ST_IDLE));
        repeat (3) @(negedge Clk);
        chk("abort_arm_no_reads", ptr0, 0);

        // Abort at beat 500 completes the frame and overrides cont
        flush();
        cont = 1'b1;
        pulse_start(1'b0);
        feed_frame(1'b0, 1'b0, 500, -1, -1);
        send_out(L, L - 1, 1'b0);
        chk("abort_feed_idle", 32'(busy), 0);
        repeat (3) @(negedge Clk);
        chk("abort_feed_reads", ptr0, L);

        // Continuous mode re-latches ch_sel switched mid-frame
        flush();
        ADC1_end = 1'b0;
        pulse_start(1'b0);
        feed_frame(1'b0, 1'b0, -1, 100, -1);
        chk("cont_f1_adc1_reads", ptr1, 0);
        send_out(L, L - 1, 1'b0);
        chk("cont_rearm_busy", 32'(busy), 1);
        chk("cont_rearm_state", 32'(dbg_state), 32'(ST_ARM));
        cont = 1'b0;
        repeat (4) @(negedge Clk);
        chk("cont_wait_adc1_end", ptr0 + ptr1, L);
        ADC1_end = 1'b1;
        feed_frame(1'b1, 1'b0, -1, -1, -1);
        chk("cont_f2_adc0_reads", ptr0, L);
        chk("cont_f2_adc1_reads", ptr1, L);
        send_out(L, L - 1, 1'b0);
        chk("cont_f2_idle", 32'(busy), 0);

        // Early source_eop sets sticky err, cleared by the next start
        flush();
        pulse_start(1'b0);
        feed_frame(1'b0, 1'b0, -1, -1, -1);
        send_out(1001, 1000, 1'b1);
        repeat (5) @(negedge Clk);
        chk("err_sticky", 32'(err), 1);
        chk("err_idle", 32'(busy), 0);
        ADC0_end = 1'b0;
        pulse_start(1'b0);
        chk("err_cleared_on_start", 32'(err), 0);
        abort = 1'b1;
        @(negedge Clk);
        abort = 1'b0;
        chk("err_abort_idle", 32'(busy), 0);

        // Reset at FEED beat 300 discards the frame
        flush();
        ADC0_end = 1'b1;
        pulse_start(1'b0);
        feed_frame(1'b0, 1'b0, -1, -1, 300);
        Reset_n = 1'b0;
        #1;
        chk("rst_rdreq_comb", 32'({ADC0_rdreq, ADC1_rdreq}), 0);
        @(negedge Clk);
        chk("rst_mid_outputs", 32'({busy, done, err, sink_valid, sink_sop, sink_eop,
                                    source_ready, ADC0_rdreq, ADC1_rdreq}), 0);
        chk("rst_mid_state", 32'(dbg_state), 32'(ST_IDLE));
        n_keep = ptr0;
        Reset_n = 1'b1;
        repeat (20) @(negedge Clk);
        chk("rst_no_reads_after", ptr0, n_keep);
        flush();
        pulse_start(1'b0);
        feed_frame(1'b0, 1'b0, -1, -1, -1);
        send_out(L, L - 1, 1'b0);
        chk("rst_recovery_idle", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
